// File: rtl/dbus_timer.sv
// dbus_timer: memory-mapped machine timer on the data bus.
// 64-bit prescaled mtime, 64-bit mtimecmp, registered level interrupt.
// Reads have the same 1-cycle latency as the data memory.
module dbus_timer #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
   parameter logic [7:0]  PRESCALE_RST = 8'd0
) (
   input  logic        i_Clk,
   input  logic        i_Rstn,
   input  logic        i_ReadEn,
   input  logic        i_WriteEn,
   input  logic [31:0] i_Addr,
   input  logic [31:0] i_WriteData,
   output logic [31:0] o_ReadData,
   output logic        o_Irq
);

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;
   localparam logic [2:0] OFF_STATUS   = 3'd5;

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        en;
   logic        ie;
   logic [7:0]  presc;
   logic [7:0]  pcnt;
   logic [31:0] hi_shadow;
   logic [31:0] rd_val;

   logic        sel;
   logic [2:0]  off;
   logic        wr;
   logic        rd;
   logic        tick;
   logic        cmp_hit;
   logic        unused_addr;

   // Byte lanes are not supported; the low address bits carry no meaning.
   assign unused_addr = ^i_Addr[1:0];

   assign sel     = (i_Addr[31:5] == BASE_ADDR[31:5]);
   assign off     = i_Addr[4:2];
   assign wr      = i_WriteEn & sel;
   assign rd      = i_ReadEn & sel;
   assign tick    = en & (pcnt == presc);
   assign cmp_hit = (mtime >= mtimecmp);

   // Register read mux; values are taken before any same-cycle write lands.
   always_comb begin
      rd_val = '0;
      case (off)
         OFF_MTIME_LO: rd_val = mtime[31:0];
         OFF_MTIME_HI: rd_val = hi_shadow;
         OFF_CMP_LO:   rd_val = mtimecmp[31:0];
         OFF_CMP_HI:   rd_val = mtimecmp[63:32];
         OFF_CTRL:     rd_val = {16'h0000, presc, 6'b000000, ie, en};
         OFF_STATUS:   rd_val = {31'h0, cmp_hit};
         default:      rd_val = '0;
      endcase
   end

   // mtime: bus writes take priority over (and discard) a pending increment.
   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn) begin
         mtime <= '0;
      end else if (wr && off == OFF_MTIME_LO) begin
         mtime[31:0] <= i_WriteData;
      end else if (wr && off == OFF_MTIME_HI) begin
         mtime[63:32] <= i_WriteData;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // Prescale counter: runs while enabled, restarts on every CTRL write.
   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn) begin
         pcnt <= '0;
      end else if (wr && off == OFF_CTRL) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= tick ? 8'd0 : pcnt + 8'd1;
      end
   end

   // Compare and control registers.
   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn) begin
         mtimecmp <= '1;
         en       <= 1'b0;
         ie       <= 1'b0;
         presc    <= PRESCALE_RST;
      end else if (wr) begin
         case (off)
            OFF_CMP_LO: mtimecmp[31:0]  <= i_WriteData;
            OFF_CMP_HI: mtimecmp[63:32] <= i_WriteData;
            OFF_CTRL: begin
               en    <= i_WriteData[0];
               ie    <= i_WriteData[1];
               presc <= i_WriteData[15:8];
            end
            default: ;
         endcase
      end
   end

   // Read data and hi-shadow; a LO read snapshots HI so LO-then-HI is coherent.
   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn) begin
         o_ReadData <= '0;
         hi_shadow  <= '0;
      end else if (rd) begin
         o_ReadData <= rd_val;
         if (off == OFF_MTIME_LO)
            hi_shadow <= mtime[63:32];
      end else if (i_ReadEn) begin
         o_ReadData <= '0;
      end
   end

   // Interrupt is a registered view of the compare, one cycle behind state.
   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn)
         o_Irq <= 1'b0;
      else
         o_Irq <= ie & cmp_hit;
   end

endmodule

// File: tb/tb_dbus_timer.sv
// tb_dbus_timer: directed and random bus traffic checked against a
// behavioural model of the timer's register semantics.
module tb_dbus_timer;

   localparam logic [31:0] BASE = 32'h0000_8000;

   logic        i_Clk = 1'b0;
   logic        i_Rstn = 1'b0;
   logic        i_ReadEn = 1'b0;
   logic        i_WriteEn = 1'b0;
   logic [31:0] i_Addr = '0;
   logic [31:0] i_WriteData = '0;
   logic [31:0] o_ReadData;
   logic        o_Irq;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic [63:0] m_time, m_cmp;
   logic        m_en, m_ie, m_irq;
   logic [7:0]  m_presc;
   int          m_phase;
   logic [31:0] m_shadow, m_rdata;

   dbus_timer #(.BASE_ADDR(BASE), .PRESCALE_RST(8'd0)) dut (
      .i_Clk(i_Clk), .i_Rstn(i_Rstn), .i_ReadEn(i_ReadEn), .i_WriteEn(i_WriteEn),
      .i_Addr(i_Addr), .i_WriteData(i_WriteData), .o_ReadData(o_ReadData), .o_Irq(o_Irq)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_time = 64'd0; m_cmp = '1; m_en = 0; m_ie = 0; m_presc = 8'd0;
      m_phase = 0; m_shadow = 0; m_rdata = 0; m_irq = 0;
   endtask

   function automatic logic [31:0] reg_val(input int o);
      case (o)
         0: return m_time[31:0];
         1: return m_shadow;
         2: return m_cmp[31:0];
         3: return m_cmp[63:32];
         4: return {16'h0, m_presc, 6'h0, m_ie, m_en};
         5: return (m_time >= m_cmp) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the timer's documented behaviour, from pre-edge state.
   task automatic model_step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
      bit in_blk = (a[31:5] == BASE[31:5]);
      int o = int'(a[4:2]);
      // mtime advances on every (PRESC+1)-th enabled cycle after a CTRL write
      bit adv = m_en && ((m_phase % (int'(m_presc) + 1)) == int'(m_presc));
      logic [63:0] n_time = adv ? m_time + 64'd1 : m_time;
      bit n_irq = m_ie && (m_time >= m_cmp);
      if (rd && in_blk) begin
         m_rdata = reg_val(o);
         if (o == 0) m_shadow = m_time[63:32];
      end else if (rd) begin
         m_rdata = 0;
      end
      if (m_en) m_phase++;
      if (wr && in_blk) begin
         case (o)
            0: n_time = {m_time[63:32], wd};
            1: n_time = {wd, m_time[31:0]};
            2: m_cmp[31:0] = wd;
            3: m_cmp[63:32] = wd;
            4: begin m_en = wd[0]; m_ie = wd[1]; m_presc = wd[15:8]; m_phase = 0; end
            default: ;
         endcase
      end
      m_time = n_time;
      m_irq = n_irq;
   endtask

   task automatic cyc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
      i_ReadEn = rd; i_WriteEn = wr; i_Addr = a; i_WriteData = wd;
      @(posedge i_Clk);
      model_step(rd, wr, a, wd);
      #1;
      i_ReadEn = 0; i_WriteEn = 0;
      chk("rdata", o_ReadData, m_rdata);
      chk("irq", {31'h0, o_Irq}, {31'h0, m_irq});
   endtask

   task automatic wr_reg(input int o, input logic [31:0] d);
      cyc(0, 1, BASE + 32'(o * 4), d);
   endtask

   task automatic rd_reg(input int o);
      cyc(1, 0, BASE + 32'(o * 4), 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      model_reset();
      #22;
      chk("rst_rdata", o_ReadData, 32'h0);
      chk("rst_irq", {31'h0, o_Irq}, 32'h0);
      i_Rstn = 1'b1;

      // reset state readback
      rd_reg(4); chk("rst_ctrl", o_ReadData, 32'h0);
      rd_reg(2); chk("rst_cmp_lo", o_ReadData, 32'hFFFF_FFFF);
      rd_reg(3); chk("rst_cmp_hi", o_ReadData, 32'hFFFF_FFFF);

      // count rate, PRESC=3
      wr_reg(0, 0); wr_reg(1, 0);
      wr_reg(4, 32'h0000_0301);
      idle(40);
      rd_reg(0);
      chk("rate_window", (o_ReadData >= 9 && o_ReadData <= 11) ? 32'd1 : 32'd0, 32'd1);

      // coherent 64-bit read across the carry
      wr_reg(4, 0); wr_reg(1, 0); wr_reg(0, 32'hFFFF_FFFE);
      wr_reg(4, 32'h1);
      idle(1);
      rd_reg(0); chk("coh_lo", o_ReadData, 32'hFFFF_FFFF);
      rd_reg(1); chk("coh_hi", o_ReadData, 32'h0);
      rd_reg(0); rd_reg(1); chk("coh_hi_after", o_ReadData, 32'h1);

      // interrupt at mtime == 20
      wr_reg(4, 0); wr_reg(3, 0); wr_reg(2, 20); wr_reg(1, 0); wr_reg(0, 0);
      wr_reg(4, 32'h3);
      for (int i = 0; i < 20; i++) begin
         idle(1);
         chk("irq_early", {31'h0, o_Irq}, 32'h0);
      end
      idle(1); chk("irq_rise", {31'h0, o_Irq}, 32'h1);
      rd_reg(5); chk("status_hit", o_ReadData, 32'h1);
      wr_reg(2, 32'hFFFF_FFFF); chk("irq_hold", {31'h0, o_Irq}, 32'h1);
      idle(1); chk("irq_drop", {31'h0, o_Irq}, 32'h0);
      rd_reg(5); chk("status_miss", o_ReadData, 32'h0);
      wr_reg(2, 20); idle(1);
      rd_reg(2); chk("irq_again", {31'h0, o_Irq}, 32'h1);

      // asynchronous reset between edges
      #2 i_Rstn = 1'b0;
      #1;
      model_reset();
      chk("arst_irq", {31'h0, o_Irq}, 32'h0);
      chk("arst_rdata", o_ReadData, 32'h0);
      @(posedge i_Clk); @(posedge i_Clk);
      #3 i_Rstn = 1'b1;
      idle(3);
      rd_reg(0); chk("arst_mtime", o_ReadData, 32'h0);

      // decode and OR-mux behaviour
      wr_reg(2, 32'h1234);
      rd_reg(2);
      cyc(1, 0, 32'h0000_0010, 0); chk("unsel_read", o_ReadData, 32'h0);
      rd_reg(2); idle(2);
      cyc(1, 0, BASE + 32'h18, 0); chk("rsvd_read", o_ReadData, 32'h0);
      cyc(0, 1, BASE + 32'h1C, 32'hFFFF_FFFF);
      cyc(0, 1, 32'h0000_000C, 32'hDEAD_BEEF);
      for (int o = 0; o < 8; o++) rd_reg(o);
      // read and write of the same register in one cycle returns the old value
      cyc(1, 1, BASE + 32'h8, 32'h55);
      rd_reg(2); chk("rw_new", o_ReadData, 32'h55);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         int op = int'($urandom_range(0, 9));
         int o  = int'($urandom_range(0, 7));
         logic [31:0] a = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
         logic [31:0] d;
         if ($urandom_range(0, 15) == 0) a = $urandom;
         case (o)
            0, 2: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 60));
            1, 3: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            4: d = ($urandom_range(0, 7) == 0) ? $urandom
                   : {16'h0, 8'($urandom_range(0, 3)), 6'h0, 2'($urandom_range(0, 3))};
            default: d = $urandom;
         endcase
         if (op < 5)       cyc(0, 0, a, d);
         else if (op < 7)  cyc(1, 0, a, d);
         else if (op < 9)  cyc(0, 1, a, d);
         else              cyc(1, 1, a, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
